// File: rtl/csa_resolver_if.sv
// Handshake bundle between a carry-save producer and csa_resolver: redundant pair in, binary total out.
interface csa_resolver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH+1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output sum_vec, carry_vec, in_valid, out_ready,
    input  in_ready, result, out_valid, busy
  );

  modport slave (
    input  sum_vec, carry_vec, in_valid, out_ready,
    output in_ready, result, out_valid, busy
  );
endinterface

// File: rtl/csa_resolver.sv
// Bit-serial carry-propagate resolver: result = sum_vec + 2*carry_vec through one full adder; WIDTH+1 clocks accept-to-valid.
// One pair in flight; in_ready low through RUN/DONE, DONE holds result until out_ready.
module csa_resolver #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  csa_resolver_if.slave io
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // a holds sum_vec bits, b holds carry_vec pre-shifted by one so both present bit i at [0]
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   b;
  } opnd_t;

  state_t           state_q, state_d;
  opnd_t            opnd_q, opnd_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic fa_a, fa_b, fa_sum, fa_cout;

  assign fa_a    = opnd_q.a[0];
  assign fa_b    = opnd_q.b[0];
  assign fa_sum  = fa_a ^ fa_b ^ c_q;
  assign fa_cout = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          opnd_d.a = io.sum_vec;
          opnd_d.b = {io.carry_vec, 1'b0};
          c_d      = 1'b0;
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q] = fa_sum;
        c_d             = fa_cout;
        opnd_d.a        = opnd_q.a >> 1;
        opnd_d.b        = opnd_q.b >> 1;
        cnt_d           = cnt_q + 1'b1;
        // Top position: the final carry becomes the MSB, no further column needed
        if (cnt_q == CNT_W'(WIDTH)) begin
          result_d[WIDTH+1] = fa_cout;
          state_d           = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.result    = result_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver at WIDTH=4: reset, extremes, full sweep, backpressure, mid-run reset, CSA feed.
module tb_csa_resolver;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  csa_resolver_if #(.WIDTH(W)) io();

  csa_resolver #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (io.out_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (io.result !== 6'd0) begin errors++; $display("FAIL rst_result got=%0d want=0", io.result); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", io.out_valid); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", io.busy); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", io.in_ready); end
    rst = 1'b0;
    step();
    io.sum_vec = 4'h5; io.carry_vec = 4'h3; io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    checks++; if (io.busy !== 1'b1 || io.in_ready !== 1'b0) begin errors++; $display("FAIL run_flags got busy=%b in_ready=%b want busy=1 in_ready=0", io.busy, io.in_ready); end
    wait_valid(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL first_latency got=%0d want=5", n); end
    checks++; if (io.result !== 6'd11) begin errors++; $display("FAIL first_result got=%0d want=11", io.result); end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin errors++; $display("FAIL handshake got out_valid=%b in_ready=%b want 0/1", io.out_valid, io.in_ready); end
    checks++; if (io.result !== 6'd11) begin errors++; $display("FAIL result_hold got=%0d want=11", io.result); end
  endtask

  task automatic test_extremes();
    logic [3:0] sv [2];
    logic [3:0] cv [2];
    logic [5:0] ev [2];
    int n;
    sv[0] = 4'hF; cv[0] = 4'hF; ev[0] = 6'd45;
    sv[1] = 4'h0; cv[1] = 4'h0; ev[1] = 6'd0;
    for (int k = 0; k < 2; k++) begin
      io.sum_vec = sv[k]; io.carry_vec = cv[k]; io.in_valid = 1'b1;
      step();
      io.in_valid = 1'b0;
      wait_valid(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL extreme_latency[%0d] got=%0d want=5", k, n); end
      checks++; if (io.result !== ev[k]) begin errors++; $display("FAIL extreme_result[%0d] got=%0d want=%0d", k, io.result, ev[k]); end
      io.out_ready = 1'b1;
      step();
      io.out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep();
    int n;
    int w;
    int t_acc;
    int t_prev;
    logic [5:0] exp_r;
    io.out_ready = 1'b1;
    t_prev = -1;
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 16; c++) begin
        w = 0;
        while (io.in_ready !== 1'b1 && w < 10) begin step(); w++; end
        io.sum_vec = 4'(s); io.carry_vec = 4'(c); io.in_valid = 1'b1;
        step();
        t_acc = cyc;
        io.in_valid = 1'b0;
        exp_r = 6'(s + 2 * c);
        if (t_prev >= 0) begin
          checks++; if (t_acc - t_prev !== 7) begin errors++; $display("FAIL sweep_interval s=%0d c=%0d got=%0d want=7", s, c, t_acc - t_prev); end
        end
        t_prev = t_acc;
        wait_valid(n);
        checks++; if (io.result !== exp_r || n !== 5) begin errors++; $display("FAIL sweep s=%0d c=%0d got=%0d lat=%0d want=%0d lat=5", s, c, io.result, n, exp_r); end
        step();
      end
    end
    io.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    io.sum_vec = 4'hA; io.carry_vec = 4'h5; io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    wait_valid(n);
    checks++; if (io.result !== 6'd20) begin errors++; $display("FAIL bp_first got=%0d want=20", io.result); end
    io.sum_vec = 4'h3; io.carry_vec = 4'hC; io.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (io.result !== 6'd20 || io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got result=%0d ov=%b ir=%b want 20/1/0", k, io.result, io.out_valid, io.in_ready);
      end
    end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    checks++; if (io.in_ready !== 1'b1 || io.busy !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b busy=%b want 1/0", io.in_ready, io.busy); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.busy !== 1'b1) begin errors++; $display("FAIL bp_accept got busy=%b want 1", io.busy); end
    wait_valid(n);
    checks++; if (io.result !== 6'd27 || n !== 5) begin errors++; $display("FAIL bp_second got=%0d lat=%0d want=27 lat=5", io.result, n); end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    int seen;
    io.sum_vec = 4'hF; io.carry_vec = 4'hF; io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    checks++; if (io.busy !== 1'b0 || io.in_ready !== 1'b1 || io.result !== 6'd0) begin errors++; $display("FAIL midrun_rst got busy=%b ir=%b result=%0d want 0/1/0", io.busy, io.in_ready, io.result); end
    seen = 0;
    repeat (2) begin step(); if (io.out_valid !== 1'b0) seen++; end
    rst = 1'b0;
    repeat (6) begin step(); if (io.out_valid !== 1'b0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_valid got=%0d want=0 cycles with out_valid", seen); end
    io.sum_vec = 4'h9; io.carry_vec = 4'h6; io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    wait_valid(n);
    checks++; if (io.result !== 6'd21 || n !== 5) begin errors++; $display("FAIL midrun_after got=%0d lat=%0d want=21 lat=5", io.result, n); end
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
  endtask

  task automatic test_csa_e2e();
    logic [2:0] op [4][4];
    int         ex [4];
    logic [2:0] s1, c1;
    logic [3:0] r2b, s2, c2;
    int n;
    op[0] = '{3'd7, 3'd7, 3'd7, 3'd7}; ex[0] = 28;
    op[1] = '{3'd1, 3'd2, 3'd3, 3'd4}; ex[1] = 10;
    op[2] = '{3'd5, 3'd0, 3'd6, 3'd3}; ex[2] = 14;
    op[3] = '{3'd2, 3'd7, 3'd1, 3'd0}; ex[3] = 10;
    for (int k = 0; k < 4; k++) begin
      s1  = op[k][0] ^ op[k][1] ^ op[k][2];
      c1  = (op[k][0] & op[k][1]) | (op[k][0] & op[k][2]) | (op[k][1] & op[k][2]);
      r2b = {c1, 1'b0};
      s2  = {1'b0, s1} ^ r2b ^ {1'b0, op[k][3]};
      c2  = ({1'b0, s1} & r2b) | ({1'b0, s1} & {1'b0, op[k][3]}) | (r2b & {1'b0, op[k][3]});
      io.sum_vec = s2; io.carry_vec = c2; io.in_valid = 1'b1;
      step();
      io.in_valid = 1'b0;
      wait_valid(n);
      checks++; if (io.result !== 6'(ex[k])) begin errors++; $display("FAIL csa_e2e[%0d] got=%0d want=%0d", k, io.result, ex[k]); end
      io.out_ready = 1'b1;
      step();
      io.out_ready = 1'b0;
    end
  endtask

  initial begin
    io.sum_vec   = '0;
    io.carry_vec = '0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    test_reset();
    test_extremes();
    test_sweep();
    test_backpressure();
    test_reset_mid_run();
    test_csa_e2e();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
